itf_offchip_port: RTL and testbench

Chip-side endpoint of the off-chip pad protocol: the responder to the host/DRAM model that drives ISA words and data into the chip. It receives ISA beats, issues DRAM read/write commands on the shared 128-bit bus, converts between 128-bit pad beats and 256-bit internal words, and streams data in both directions. It sits between the pad ring (async FIFO bypassed, single clock) and the internal GLB/CCU logic.

---
 rtl/itf_offchip_port_pkg.sv | 11 +
 rtl/itf_offchip_port_if.sv | 26 ++
 rtl/itf_offchip_port_gearbox.sv | 53 +++++
 rtl/itf_offchip_port.sv | 118 +++++++++++
 tb/tb_itf_offchip_port.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/itf_offchip_port_pkg.sv
// itf_offchip_port_pkg: shared types, widths and command-beat field offsets for the off-chip pad port
package itf_offchip_port_pkg;
    localparam int PAD_W = 128;
    localparam int WORD_W = 256;
    localparam int DADDR_W = 32;
    localparam int NUM_W = 16;
    localparam int WR_BIT = 0;
    localparam int ADDR_LSB = 1;
    localparam int NUM_LSB = 33;
    typedef enum logic [2:0] {ST_IDLE, ST_ISA, ST_CMD, ST_IN, ST_OUT} portState_e;
endpackage

// File: rtl/itf_offchip_port_if.sv
// itf_offchip_port_if: pad-side bus between the host/DRAM model (master) and the chip port (slave)
interface itf_offchip_port_if
    import itf_offchip_port_pkg::*;
#(
    parameter int PORT_WIDTH = PAD_W
);
    logic [PORT_WIDTH-1:0] io_dat_in;
    logic [PORT_WIDTH-1:0] io_dat_out;
    logic o_dat_oe;
    logic i_dat_vld;
    logic i_dat_last;
    logic i_isa_vld;
    logic o_dat_rdy;
    logic o_dat_vld;
    logic o_dat_last;
    logic o_cmd_vld;
    logic i_dat_rdy;
    modport master (
        output io_dat_in, i_dat_vld, i_dat_last, i_isa_vld, i_dat_rdy,
        input  io_dat_out, o_dat_oe, o_dat_rdy, o_dat_vld, o_dat_last, o_cmd_vld
    );
    modport slave (
        input  io_dat_in, i_dat_vld, i_dat_last, i_isa_vld, i_dat_rdy,
        output io_dat_out, o_dat_oe, o_dat_rdy, o_dat_vld, o_dat_last, o_cmd_vld
    );
endinterface

// File: rtl/itf_offchip_port_gearbox.sv
// itf_offchip_port_gearbox: one-word buffer bridging 128-bit pad beats and 256-bit internal words
module itf_offchip_port_gearbox #(
    parameter int PORT_WIDTH = 128,
    parameter int WORD_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  beatLd,
    input  logic                  beatLast,
    input  logic [PORT_WIDTH-1:0] beatDat,
    input  logic                  rdRdy,
    output logic                  rdVld,
    input  logic                  wordLd,
    input  logic [WORD_WIDTH-1:0] wordDat,
    input  logic                  padAdv,
    output logic                  padVld,
    output logic [PORT_WIDTH-1:0] padDat,
    output logic [WORD_WIDTH-1:0] bufWord,
    output logic                  bufFull,
    output logic                  bufHi
);
    logic wrOwn;
    assign rdVld = bufFull && !wrOwn;
    assign padVld = bufFull && wrOwn;
    assign padDat = bufHi ? bufWord[WORD_WIDTH-1 -: PORT_WIDTH] : bufWord[PORT_WIDTH-1:0];
    // fill halves from pad beats (a last beat on the low half drops the partial word), load whole words for output, drain by word or by half
    always_ff @(posedge clk)
        if (rst) begin
            bufWord <= '0;
            bufFull <= 1'b0;
            bufHi <= 1'b0;
            wrOwn <= 1'b0;
        end else begin
            if (rdVld && rdRdy) bufFull <= 1'b0;
            if (beatLd) begin
                if (bufHi) bufWord[WORD_WIDTH-1 -: PORT_WIDTH] <= beatDat;
                else bufWord[PORT_WIDTH-1:0] <= beatDat;
                bufHi <= !bufHi && !beatLast;
                if (bufHi) begin
                    bufFull <= 1'b1;
                    wrOwn <= 1'b0;
                end
            end else if (wordLd) begin
                bufWord <= wordDat;
                bufFull <= 1'b1;
                bufHi <= 1'b0;
                wrOwn <= 1'b1;
            end else if (padAdv) begin
                bufHi <= !bufHi;
                if (bufHi) bufFull <= 1'b0;
            end
        end
endmodule

// File: rtl/itf_offchip_port.sv
// itf_offchip_port: chip-side responder of the off-chip pad protocol (ISA intake, DRAM commands, read/write streaming)
module itf_offchip_port
    import itf_offchip_port_pkg::*;
#(
    parameter int PORT_WIDTH = PAD_W,
    parameter int WORD_WIDTH = WORD_W,
    parameter int DRAM_ADDR_WIDTH = DADDR_W,
    parameter int ADDR_WIDTH = NUM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    itf_offchip_port_if.slave          pad,
    input  logic                       cmd_vld,
    output logic                       cmd_rdy,
    input  logic                       cmd_wr,
    input  logic [DRAM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0]      cmd_num,
    output logic [WORD_WIDTH-1:0]      rdat,
    output logic                       rdat_vld,
    input  logic                       rdat_rdy,
    input  logic [WORD_WIDTH-1:0]      wdat,
    input  logic                       wdat_vld,
    output logic                       wdat_rdy,
    output logic [PORT_WIDTH-1:0]      isa_dat,
    output logic                       isa_vld,
    output logic                       isa_last,
    input  logic                       isa_rdy,
    output logic                       err
);
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    portState_e state, nextState;
    logic cmdWr;
    logic [DRAM_ADDR_WIDTH-1:0] cmdAddr;
    logic [ADDR_WIDTH-1:0] cmdNum;
    logic [ADDR_WIDTH:0] beatCnt, lastIdx;
    logic [PORT_WIDTH-1:0] cmdBeat, padDat;
    logic isaBeat, cmdTake, inAcc, outAcc, isLast, inRange, bufFull, bufHi, rdVld, padVld;
    assign lastIdx = {cmdNum, 1'b0} - ONE;
    assign isLast = beatCnt == lastIdx;
    assign inRange = beatCnt <= lastIdx;
    assign isaBeat = pad.i_isa_vld && pad.i_dat_vld;
    assign cmdTake = state == ST_IDLE && !isaBeat && cmd_vld;
    assign inAcc = state == ST_IN && pad.i_dat_vld && pad.o_dat_rdy;
    assign outAcc = state == ST_OUT && pad.o_dat_vld && pad.i_dat_rdy;
    itf_offchip_port_gearbox #(
        .PORT_WIDTH(PORT_WIDTH),
        .WORD_WIDTH(WORD_WIDTH)
    ) u_gearbox (
        .clk(clk),
        .rst(rst),
        .beatLd(inAcc && inRange),
        .beatLast(pad.i_dat_last),
        .beatDat(pad.io_dat_in),
        .rdRdy(rdat_rdy),
        .rdVld(rdVld),
        .wordLd(wdat_vld && wdat_rdy),
        .wordDat(wdat),
        .padAdv(outAcc),
        .padVld(padVld),
        .padDat(padDat),
        .bufWord(rdat),
        .bufFull(bufFull),
        .bufHi(bufHi)
    );
    // state register
    always_ff @(posedge clk)
        if (rst) state <= ST_IDLE;
        else state <= nextState;
    // next state: a committed ISA beat beats a same-cycle command; zero-length commands never leave IDLE
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: nextState = isaBeat ? ST_ISA : (cmd_vld && cmd_num != '0) ? ST_CMD : ST_IDLE;
            ST_ISA:  nextState = (isa_vld && isa_rdy && pad.i_dat_last) ? ST_IDLE : ST_ISA;
            ST_CMD:  nextState = pad.i_dat_rdy ? (cmdWr ? ST_OUT : ST_IN) : ST_CMD;
            ST_IN:   nextState = (inAcc && pad.i_dat_last) ? ST_IDLE : ST_IN;
            ST_OUT:  nextState = (outAcc && isLast) ? ST_IDLE : ST_OUT;
            default: nextState = ST_IDLE;
        endcase
    end
    // command latch, beat counter (stops one past the final index) and sticky error
    always_ff @(posedge clk)
        if (rst) begin
            cmdWr <= 1'b0;
            cmdAddr <= '0;
            cmdNum <= '0;
            beatCnt <= '0;
            err <= 1'b0;
        end else begin
            if (cmdTake) begin
                cmdWr <= cmd_wr;
                cmdAddr <= cmd_addr;
                cmdNum <= cmd_num;
                beatCnt <= '0;
            end
            if ((inAcc || outAcc) && inRange) beatCnt <= beatCnt + ONE;
            if ((cmdTake && cmd_num == '0) || (inAcc && (pad.i_dat_last ? !isLast : !inRange))) err <= 1'b1;
        end
    // pad outputs decoded from state and buffer; internal handshakes pass through in the owning state
    always_comb begin
        cmdBeat = '0;
        cmdBeat[WR_BIT] = cmdWr;
        cmdBeat[ADDR_LSB +: DRAM_ADDR_WIDTH] = cmdAddr;
        cmdBeat[NUM_LSB +: ADDR_WIDTH] = cmdNum;
        pad.io_dat_out = state == ST_CMD ? cmdBeat : state == ST_OUT ? padDat : '0;
        pad.o_dat_oe = state == ST_CMD || state == ST_OUT;
        pad.o_dat_vld = state == ST_CMD || (state == ST_OUT && padVld);
        pad.o_cmd_vld = state == ST_CMD;
        pad.o_dat_last = state == ST_OUT && padVld && isLast;
        pad.o_dat_rdy = state == ST_ISA ? isa_rdy : state == ST_IN ? (!rdVld || rdat_rdy) : 1'b0;
        cmd_rdy = cmdTake;
        isa_dat = state == ST_ISA ? pad.io_dat_in : '0;
        isa_vld = state == ST_ISA && isaBeat;
        isa_last = state == ST_ISA && pad.i_dat_last;
        rdat_vld = rdVld;
        wdat_rdy = state == ST_OUT && (!bufFull || (padVld && bufHi && pad.i_dat_rdy && !isLast));
    end
endmodule

// File: tb/tb_itf_offchip_port.sv
// tb_itf_offchip_port: directed vectors with hand-computed expectations for the off-chip pad port
module tb_itf_offchip_port;
    import itf_offchip_port_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic cmd_vld, cmd_rdy, cmd_wr;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_num;
    logic [255:0] rdat, wdat;
    logic rdat_vld, rdat_rdy, wdat_vld, wdat_rdy;
    logic [127:0] isa_dat;
    logic isa_vld, isa_last, isa_rdy, err;
    int nVec = 0;
    int nErr = 0;
    int nIsa;
    itf_offchip_port_if pad();
    itf_offchip_port dut (
        .clk(clk), .rst(rst), .pad(pad),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_num(cmd_num),
        .rdat(rdat), .rdat_vld(rdat_vld), .rdat_rdy(rdat_rdy),
        .wdat(wdat), .wdat_vld(wdat_vld), .wdat_rdy(wdat_rdy),
        .isa_dat(isa_dat), .isa_vld(isa_vld), .isa_last(isa_last), .isa_rdy(isa_rdy),
        .err(err)
    );

    function automatic logic [127:0] isab(input int k);
        return {32'h15A0_0000 + 32'(k), 96'h0};
    endfunction
    function automatic logic [127:0] rb(input int k);
        return {32'hDA7A_0000 + 32'(k), 64'h0123_4567_89AB_CDEF, 32'(k)};
    endfunction
    function automatic logic [127:0] wbeat(input int j);
        return {32'h5EED_0000 + 32'(j), 64'hFEED_FACE_CAFE_BEEF, ~32'(j)};
    endfunction
    function automatic logic [255:0] wword(input int k);
        return {wbeat(2 * k + 1), wbeat(2 * k)};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_out(input int n, input bit toggle);
        int nb = 0;
        int wi = 0;
        logic hsW, hsP;
        for (int c = 0; c < 60 && nb < 2 * n; c++) begin
            pad.i_dat_rdy = !toggle || (c % 2 == 1);
            wdat_vld = wi < n;
            wdat = wword(wi);
            #1;
            if (pad.o_dat_vld) begin
                chk("wr_beat", pad.io_dat_out, wbeat(nb));
                chk("wr_last", pad.o_dat_last, nb == 2 * n - 1);
                chk("wr_oe", pad.o_dat_oe, 1'b1);
            end
            hsW = wdat_vld && wdat_rdy;
            hsP = pad.o_dat_vld && pad.i_dat_rdy;
            cyc();
            if (hsW) wi++;
            if (hsP) nb++;
        end
        wdat_vld = 1'b0;
        pad.i_dat_rdy = 1'b0;
        chk("wr_beats", nb, 2 * n);
        chk("wr_words", wi, n);
        chk("wr_idle", dut.state, ST_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        cmd_vld = 0; cmd_wr = 0; cmd_addr = '0; cmd_num = '0;
        rdat_rdy = 0; wdat = '0; wdat_vld = 0; isa_rdy = 0;
        pad.io_dat_in = '0; pad.i_dat_vld = 0; pad.i_dat_last = 0; pad.i_isa_vld = 0; pad.i_dat_rdy = 0;
        repeat (2) cyc();
        chk("rst_pad", {pad.io_dat_out, pad.o_dat_oe, pad.o_dat_vld, pad.o_cmd_vld, pad.o_dat_last, pad.o_dat_rdy}, '0);
        chk("rst_int", {cmd_rdy, rdat_vld, wdat_rdy, isa_vld, isa_last, err}, '0);
        chk("rst_state", dut.state, ST_IDLE);
        rst = 0;
        // ISA beat and command offered together: ISA first
        cmd_vld = 1; cmd_wr = 0; cmd_addr = 32'h100; cmd_num = 16'd3;
        isa_rdy = 1; pad.i_dat_vld = 1; pad.i_isa_vld = 1; pad.io_dat_in = isab(0);
        #1 chk("isa_wins_cmd_rdy", cmd_rdy, 1'b0);
        cyc();
        nIsa = 0;
        for (int i = 0; i < 16; i++) begin
            pad.io_dat_in = isab(i);
            pad.i_dat_last = (i == 15);
            #1;
            chk("isa_vld", isa_vld, 1'b1);
            chk("isa_dat", isa_dat, isab(i));
            chk("isa_last", isa_last, i == 15);
            chk("isa_oe", pad.o_dat_oe, 1'b0);
            chk("isa_cmd_rdy", cmd_rdy, 1'b0);
            if (isa_vld && pad.o_dat_rdy) nIsa++;
            cyc();
        end
        pad.i_dat_vld = 0; pad.i_isa_vld = 0; pad.i_dat_last = 0;
        chk("isa_count", nIsa, 16);
        chk("isa_done_state", dut.state, ST_IDLE);
        #1 chk("cmd_after_isa", cmd_rdy, 1'b1);
        cyc();
        cmd_vld = 0;
        // read addr 0x100 num 3
        chk("rd_cmd_beat", pad.io_dat_out, 128'h6_0000_0200);
        chk("rd_cmd_flags", {pad.o_cmd_vld, pad.o_dat_vld, pad.o_dat_oe, pad.o_dat_last}, 4'b1110);
        pad.i_dat_rdy = 1;
        cyc();
        pad.i_dat_rdy = 0;
        rdat_rdy = 1;
        for (int k = 0; k < 6; k++) begin
            pad.i_dat_vld = 1;
            pad.io_dat_in = rb(k);
            pad.i_dat_last = (k == 5);
            #1;
            chk("rd_rdy", pad.o_dat_rdy, 1'b1);
            chk("rd_oe", pad.o_dat_oe, 1'b0);
            cyc();
            chk("rd_word_vld", rdat_vld, k % 2);
            if (k % 2 == 1) chk("rd_word", rdat, {rb(k), rb(k - 1)});
        end
        pad.i_dat_vld = 0; pad.i_dat_last = 0;
        chk("rd_done", dut.state, ST_IDLE);
        chk("rd_err", err, 1'b0);
        cyc();
        chk("rd_drained", rdat_vld, 1'b0);
        // write addr 0x40 num 2 with host ready toggling
        cmd_vld = 1; cmd_wr = 1; cmd_addr = 32'h40; cmd_num = 16'd2;
        #1 chk("wr_cmd_rdy", cmd_rdy, 1'b1);
        cyc();
        cmd_vld = 0;
        chk("wr_cmd_beat", pad.io_dat_out, 128'h4_0000_0081);
        cyc();
        chk("wr_cmd_hold", {pad.o_cmd_vld, pad.io_dat_out}, {1'b1, 128'h4_0000_0081});
        pad.i_dat_rdy = 1;
        cyc();
        chk("wr_out_state", dut.state, ST_OUT);
        chk("wr_empty", {pad.o_dat_vld, wdat_rdy}, 2'b01);
        run_out(2, 1'b1);
        // read num 2 with last on beat 1
        chk("pre_err", err, 1'b0);
        cmd_vld = 1; cmd_wr = 0; cmd_addr = 32'h200; cmd_num = 16'd2;
        cyc();
        cmd_vld = 0;
        pad.i_dat_rdy = 1;
        cyc();
        pad.i_dat_rdy = 0;
        rdat_rdy = 0;
        pad.i_dat_vld = 1; pad.io_dat_in = rb(10);
        cyc();
        pad.io_dat_in = rb(11); pad.i_dat_last = 1;
        cyc();
        pad.i_dat_vld = 0; pad.i_dat_last = 0;
        chk("early_last_state", dut.state, ST_IDLE);
        chk("early_last_err", err, 1'b1);
        chk("early_word_vld", rdat_vld, 1'b1);
        chk("early_word", rdat, {rb(11), rb(10)});
        rdat_rdy = 1;
        cyc();
        chk("early_drained", rdat_vld, 1'b0);
        rdat_rdy = 0;
        // zero-length command
        rst = 1;
        cyc();
        rst = 0;
        chk("rst2_err", err, 1'b0);
        cmd_vld = 1; cmd_wr = 0; cmd_num = 16'd0;
        #1 chk("num0_rdy", cmd_rdy, 1'b1);
        cyc();
        cmd_vld = 0;
        chk("num0_err", err, 1'b1);
        chk("num0_pad", {pad.o_dat_oe, pad.o_dat_vld, pad.o_cmd_vld, pad.o_dat_rdy, pad.io_dat_out}, '0);
        chk("num0_state", dut.state, ST_IDLE);
        // reset in the middle of a write
        cmd_vld = 1; cmd_wr = 1; cmd_addr = 32'h10; cmd_num = 16'd2;
        cyc();
        cmd_vld = 0;
        pad.i_dat_rdy = 1;
        cyc();
        wdat_vld = 1; wdat = wword(7);
        cyc();
        wdat_vld = 0;
        cyc();
        chk("mid_out_vld", pad.o_dat_vld, 1'b1);
        chk("mid_out_beat", pad.io_dat_out, wbeat(15));
        rst = 1; pad.i_dat_rdy = 0;
        cyc();
        chk("rst_mid_pad", {pad.io_dat_out, pad.o_dat_oe, pad.o_dat_vld, pad.o_cmd_vld, pad.o_dat_last, pad.o_dat_rdy}, '0);
        chk("rst_mid_int", {cmd_rdy, rdat_vld, wdat_rdy, isa_vld, isa_last, err}, '0);
        chk("rst_mid_rdat", rdat, '0);
        chk("rst_mid_state", dut.state, ST_IDLE);
        rst = 0;
        cmd_vld = 1; cmd_wr = 1; cmd_addr = 32'h20; cmd_num = 16'd1;
        cyc();
        cmd_vld = 0;
        chk("post_rst_cmd_beat", pad.io_dat_out, 128'h2_0000_0041);
        pad.i_dat_rdy = 1;
        cyc();
        run_out(1, 1'b0);
        chk("final_err", err, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
